// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the dual-clock FIFO: synchronises the Gray read pointer,
// advances the write pointers and derives full, almost-full, fill level and sticky overflow.
module fifo_wr_ctrl #(
  parameter int Addr         = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic          wrclk,
  input  logic          rst,
  input  logic          wrreq,
  input  logic          clr_ovf,
  input  logic [Addr:0] rdptr,
  output logic          wren,
  output logic [Addr:0] wraddr,
  output logic [Addr:0] wrptr,
  output logic          full,
  output logic          almost_full,
  output logic [Addr:0] wrlevel,
  output logic          overflow
);

  localparam logic [Addr:0] AfullThr = (Addr+1)'(AFULL_THRESH);

  logic [Addr:0] rdSync_q [SYNC_STAGES];
  logic [Addr:0] wrAddr_q, wrAddr_d;
  logic [Addr:0] wrPtr_q, wrPtr_d;
  logic [Addr:0] level_q, level_d;
  logic          full_q, full_d;
  logic          almostFull_q, almostFull_d;
  logic          overflow_q, overflow_d;
  logic [Addr:0] rq;
  logic [Addr:0] rdBin;

  assign rq = rdSync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits from the MSB down to that position.
  always_comb begin
    rdBin = '0;
    for (int i = 0; i <= Addr; i++) begin
      rdBin[i] = ^(rq >> i);
    end
  end

  assign wren = wrreq & ~full_q;

  always_comb begin
    wrAddr_d     = wrAddr_q + {{Addr{1'b0}}, wren};
    wrPtr_d      = wrAddr_d ^ (wrAddr_d >> 1);
    full_d       = (wrPtr_d == {~rq[Addr:Addr-1], rq[Addr-2:0]});
    level_d      = wrAddr_d - rdBin;
    almostFull_d = (level_d >= AfullThr);
    overflow_d   = overflow_q;
    if (wrreq && full_q) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge wrclk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rdSync_q[i] <= '0;
      end
      wrAddr_q     <= '0;
      wrPtr_q      <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      almostFull_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rdSync_q[0] <= rdptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rdSync_q[i] <= rdSync_q[i-1];
      end
      wrAddr_q     <= wrAddr_d;
      wrPtr_q      <= wrPtr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      almostFull_q <= almostFull_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wraddr      = wrAddr_q;
  assign wrptr       = wrPtr_q;
  assign wrlevel     = level_q;
  assign full        = full_q;
  assign almost_full = almostFull_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomised and directed bench for fifo_wr_ctrl, compared against a counter-based FIFO model.
module tb_fifo_wr_ctrl;

  localparam int Addr  = 3;
  localparam int Sync  = 2;
  localparam int Thr   = 6;
  localparam int Depth = 1 << Addr;
  localparam int Mask  = (2 * Depth) - 1;

  logic          wrclk = 1'b0;
  logic          rst = 1'b0;
  logic          wrreq = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [Addr:0] rdptr = '0;
  logic          wren;
  logic [Addr:0] wraddr;
  logic [Addr:0] wrptr;
  logic          full;
  logic          almost_full;
  logic [Addr:0] wrlevel;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Model: pointers as plain counts modulo twice the depth, the synchroniser as a delay queue.
  int mWr = 0;
  int mLevel = 0;
  bit mFull = 0;
  bit mAfull = 0;
  bit mOvf = 0;
  int rqHist[$];
  int rdCount = 0;

  fifo_wr_ctrl #(.Addr(Addr), .SYNC_STAGES(Sync), .AFULL_THRESH(Thr)) dut (
    .wrclk(wrclk), .rst(rst), .wrreq(wrreq), .clr_ovf(clr_ovf), .rdptr(rdptr),
    .wren(wren), .wraddr(wraddr), .wrptr(wrptr), .full(full),
    .almost_full(almost_full), .wrlevel(wrlevel), .overflow(overflow)
  );

  always #5 wrclk = ~wrclk;

  function automatic int toGray(int b);
    return (b ^ (b >> 1)) & Mask;
  endfunction

  function automatic int fromGray(int g);
    int b = 0;
    for (int i = Addr; i >= 0; i--) begin
      b = b | ((((b >> (i + 1)) ^ (g >> i)) & 1) << i);
    end
    return b;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic resetHistory();
    rqHist.delete();
    for (int i = 0; i < Sync; i++) rqHist.push_back(0);
  endtask

  // One write-clock cycle: drive inputs, check the combinational strobe, advance the model, check registers.
  task automatic applyStimulus(input bit req, input bit clr, input bit rs, input int rdg);
    int rqUse;
    bit accept;
    @(negedge wrclk);
    wrreq   = req;
    clr_ovf = clr;
    rst     = rs;
    rdptr   = rdg[Addr:0];
    #1;
    accept = req && !mFull;
    checkOutput("wren", int'(wren), int'(accept));
    if (rs) begin
      mWr = 0; mLevel = 0; mFull = 0; mAfull = 0; mOvf = 0;
      resetHistory();
    end else begin
      rqUse = rqHist.pop_front();
      rqHist.push_back(rdg);
      if (req && mFull) mOvf = 1;
      else if (clr) mOvf = 0;
      mWr    = (mWr + int'(accept)) & Mask;
      mLevel = (mWr - fromGray(rqUse)) & Mask;
      mFull  = (mLevel == Depth);
      mAfull = (mLevel >= Thr);
    end
    @(posedge wrclk);
    #1;
    checkOutput("wraddr", int'(wraddr), mWr);
    checkOutput("wrptr", int'(wrptr), toGray(mWr));
    checkOutput("wrlevel", int'(wrlevel), mLevel);
    checkOutput("full", int'(full), int'(mFull));
    checkOutput("almost_full", int'(almost_full), int'(mAfull));
    checkOutput("overflow", int'(overflow), int'(mOvf));
  endtask

  initial begin
    resetHistory();

    // Reset while requesting writes with a non-zero read pointer.
    applyStimulus(1, 0, 1, 4'b1010);
    applyStimulus(1, 0, 1, 4'b1010);
    checkOutput("reset_level", int'(wrlevel), 0);
    checkOutput("reset_wraddr", int'(wraddr), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_reset_level", int'(wrlevel), 1);

    // Fill from empty; the ninth request hits a full FIFO.
    applyStimulus(0, 0, 1, 0);
    rdCount = 0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1, 0, 0, 0);
      if (i == 6) checkOutput("fill_afull6", int'(almost_full), 1);
      if (i == 8) begin
        checkOutput("fill_full8", int'(full), 1);
        checkOutput("fill_level8", int'(wrlevel), 8);
        checkOutput("fill_wrptr8", int'(wrptr), 4'b1100);
        checkOutput("fill_wren_blocked", int'(wren), 0);
      end
    end
    checkOutput("fill_wraddr_hold", int'(wraddr), 8);
    checkOutput("ovf_set", int'(overflow), 1);

    // Overflow clear, then set beats clear.
    applyStimulus(0, 1, 0, 0);
    checkOutput("ovf_clear", int'(overflow), 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("ovf_set_wins", int'(overflow), 1);

    // One read becomes visible only after the synchroniser delay.
    rdCount = 1;
    applyStimulus(0, 0, 0, toGray(rdCount));
    checkOutput("drain_full_e1", int'(full), 1);
    applyStimulus(0, 0, 0, toGray(rdCount));
    checkOutput("drain_full_e2", int'(full), 1);
    applyStimulus(0, 0, 0, toGray(rdCount));
    checkOutput("drain_full_e3", int'(full), 0);
    checkOutput("drain_level_e3", int'(wrlevel), 7);
    checkOutput("drain_afull_e3", int'(almost_full), 1);

    // Drain completely, then write eight more so the write pointer wraps.
    while (rdCount < 8) begin
      rdCount++;
      applyStimulus(0, 0, 0, toGray(rdCount));
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, toGray(rdCount));
    checkOutput("wrap_empty", int'(wrlevel), 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, toGray(rdCount));
    checkOutput("wrap_wraddr", int'(wraddr), 0);
    checkOutput("wrap_wrptr", int'(wrptr), 0);
    checkOutput("wrap_full", int'(full), 1);
    checkOutput("wrap_level", int'(wrlevel), 8);

    // Reset while full with overflow set.
    applyStimulus(1, 0, 0, toGray(rdCount));
    checkOutput("mid_ovf", int'(overflow), 1);
    applyStimulus(1, 0, 1, toGray(rdCount));
    rdCount = 0;
    checkOutput("mid_full", int'(full), 0);
    checkOutput("mid_ovf_clr", int'(overflow), 0);
    checkOutput("mid_wren", int'(wren), 1);

    // Random traffic: reads only ever consume entries that have really been written.
    for (int n = 0; n < 400; n++) begin
      bit req, clr, rs;
      req = ($urandom_range(0, 99) < 65);
      clr = ($urandom_range(0, 99) < 10);
      rs  = ($urandom_range(0, 99) < 2);
      if (((mWr - rdCount) & Mask) > 0 && $urandom_range(0, 99) < 45)
        rdCount = (rdCount + 1) & Mask;
      if (rs) rdCount = 0;
      applyStimulus(req, clr, rs, toGray(rdCount));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
